mem_sched: RTL and testbench

MEM_SCHED -- requirements
Module: mem_sched

---
 rtl/mem_sched_pkg.sv | 24 ++
 rtl/mem_sched_pick.sv | 28 ++
 rtl/mem_sched.sv | 136 +++++++++++++
 tb/tb_mem_sched.sv | 378 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_sched_pkg.sv
// Shared types and constants for the memory scheduler: FSM states, grant codes,
// the data value returned on a bus timeout, and default parameters.
package mem_sched_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_IC_RD = 3'd1,
    ST_DC_RD = 3'd2,
    ST_DC_WR = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    GNT_NONE  = 2'd0,
    GNT_IC    = 2'd1,
    GNT_DC_RD = 2'd2,
    GNT_DC_WR = 2'd3
  } grant_t;

  localparam logic [31:0] BUS_ERR_DATA     = 32'hDEAD_BEEF;
  localparam int          DEF_STARVE_LIMIT = 4;
  localparam int          DEF_TIMEOUT      = 255;

endpackage

// File: rtl/mem_sched_pick.sv
// Combinational requester selection: fixed priority dc_write > dc_read > ic_read,
// with ic_read forced to win once it has waited STARVE_LIMIT data-side grants.
import mem_sched_pkg::*;

module mem_sched_pick #(
  parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
  input  logic       ic_read_req,
  input  logic       dc_read_req,
  input  logic       dc_write_req,
  input  logic [7:0] starve_cnt,
  output grant_t     pick
);

  always_comb begin
    pick = GNT_NONE;
    if (ic_read_req && (starve_cnt == 8'(STARVE_LIMIT))) begin
      pick = GNT_IC;
    end else if (dc_write_req) begin
      pick = GNT_DC_WR;
    end else if (dc_read_req) begin
      pick = GNT_DC_RD;
    end else if (ic_read_req) begin
      pick = GNT_IC;
    end
  end

endmodule

// File: rtl/mem_sched.sv
// Single-outstanding memory scheduler for IC read, DC read and DC write ports.
// Grant one edge after request in IDLE; ack one cycle after mem_ack (or timeout); requests wait while busy.
import mem_sched_pkg::*;

module mem_sched #(
  parameter int STARVE_LIMIT = DEF_STARVE_LIMIT,
  parameter int TIMEOUT      = DEF_TIMEOUT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ic_read_req,
  input  logic [31:0] ic_read_addr,
  output logic        ic_read_ack,
  output logic [31:0] ic_read_data,
  input  logic        dc_read_req,
  input  logic [31:0] dc_read_addr,
  output logic        dc_read_ack,
  output logic [31:0] dc_read_data,
  input  logic        dc_write_req,
  input  logic [31:0] dc_write_addr,
  input  logic [31:0] dc_write_data,
  output logic        dc_write_ack,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_data_write,
  input  logic        mem_ack,
  input  logic [31:0] mem_data_read,
  output logic        bus_error,
  output logic [1:0]  grant
);

  state_t      state, state_nxt;
  grant_t      owner, pick;
  logic [7:0]  starve_cnt, tmo_cnt;
  logic [31:0] addr_q, wdata_q, ic_data_q, dc_data_q;
  logic        err_q;
  logic        busy, granting, tmo_hit;

  mem_sched_pick #(.STARVE_LIMIT(STARVE_LIMIT)) u_pick (
    .ic_read_req  (ic_read_req),
    .dc_read_req  (dc_read_req),
    .dc_write_req (dc_write_req),
    .starve_cnt   (starve_cnt),
    .pick         (pick)
  );

  assign busy     = (state == ST_IC_RD) || (state == ST_DC_RD) || (state == ST_DC_WR);
  assign granting = (state == ST_IDLE) && (pick != GNT_NONE);
  // mem_ack on the timeout edge takes precedence, so the timeout only fires without it
  assign tmo_hit  = busy && !mem_ack && (tmo_cnt == 8'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    mem_read     = 1'b0;
    mem_write    = 1'b0;
    ic_read_ack  = 1'b0;
    dc_read_ack  = 1'b0;
    dc_write_ack = 1'b0;
    grant        = GNT_NONE;
    case (state)
      ST_IDLE: begin
        case (pick)
          GNT_IC:    state_nxt = ST_IC_RD;
          GNT_DC_RD: state_nxt = ST_DC_RD;
          GNT_DC_WR: state_nxt = ST_DC_WR;
          default:   state_nxt = ST_IDLE;
        endcase
      end
      ST_IC_RD, ST_DC_RD, ST_DC_WR: begin
        mem_read  = (state != ST_DC_WR);
        mem_write = (state == ST_DC_WR);
        grant     = owner;
        if (mem_ack || tmo_hit) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        grant        = owner;
        ic_read_ack  = (owner == GNT_IC);
        dc_read_ack  = (owner == GNT_DC_RD);
        dc_write_ack = (owner == GNT_DC_WR);
        state_nxt    = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      owner      <= GNT_NONE;
      addr_q     <= '0;
      wdata_q    <= '0;
      starve_cnt <= '0;
      tmo_cnt    <= '0;
    end else if (granting) begin
      owner   <= pick;
      tmo_cnt <= '0;
      case (pick)
        GNT_IC:    addr_q <= ic_read_addr;
        GNT_DC_RD: addr_q <= dc_read_addr;
        default:   addr_q <= dc_write_addr;
      endcase
      if (pick == GNT_DC_WR) wdata_q <= dc_write_data;
      // only data grants made over a waiting IC request count towards starvation
      if ((pick != GNT_IC) && ic_read_req)
        starve_cnt <= (starve_cnt == 8'(STARVE_LIMIT)) ? starve_cnt : starve_cnt + 8'd1;
      else
        starve_cnt <= '0;
    end else if (busy) begin
      tmo_cnt <= tmo_cnt + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ic_data_q <= '0;
      dc_data_q <= '0;
      err_q     <= 1'b0;
    end else if (busy && (mem_ack || tmo_hit)) begin
      if (state == ST_IC_RD) ic_data_q <= mem_ack ? mem_data_read : BUS_ERR_DATA;
      if (state == ST_DC_RD) dc_data_q <= mem_ack ? mem_data_read : BUS_ERR_DATA;
      if (tmo_hit)           err_q     <= 1'b1;
    end
  end

  assign mem_addr       = addr_q;
  assign mem_data_write = wdata_q;
  assign ic_read_data   = ic_data_q;
  assign dc_read_data   = dc_data_q;
  assign bus_error      = err_q;

endmodule

// File: tb/tb_mem_sched.sv
// Self-checking bench for mem_sched: directed scenarios plus randomized traffic
// checked against a grant-order / data model kept in the bench.
import mem_sched_pkg::*;

module tb_mem_sched;

  localparam int LIMIT = 4;
  localparam int TMO   = 255;

  logic        clk = 1'b0;
  logic        reset;
  logic        ic_read_req, dc_read_req, dc_write_req;
  logic [31:0] ic_read_addr, dc_read_addr, dc_write_addr, dc_write_data;
  logic        ic_read_ack, dc_read_ack, dc_write_ack;
  logic [31:0] ic_read_data, dc_read_data;
  logic        mem_read, mem_write, mem_ack, bus_error;
  logic [31:0] mem_addr, mem_data_write, mem_data_read;
  logic [1:0]  grant;

  int compared   = 0;
  int mismatched = 0;

  // responder / monitor state
  int          busy_n;
  bit          resp_en, rand_mode, stray, fix_vld;
  int          resp_lat;
  logic [31:0] fix_data, exp_rd, last_resp;
  bit          exp_rd_vld;
  int          model_starve;
  logic [1:0]  prev_grant, cur_owner;
  int          ack_cnt[4];
  bit          acked_now[4];
  int          grant_log[$];

  always #5 clk = ~clk;

  mem_sched #(.STARVE_LIMIT(LIMIT), .TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset),
    .ic_read_req(ic_read_req), .ic_read_addr(ic_read_addr),
    .ic_read_ack(ic_read_ack), .ic_read_data(ic_read_data),
    .dc_read_req(dc_read_req), .dc_read_addr(dc_read_addr),
    .dc_read_ack(dc_read_ack), .dc_read_data(dc_read_data),
    .dc_write_req(dc_write_req), .dc_write_addr(dc_write_addr),
    .dc_write_data(dc_write_data), .dc_write_ack(dc_write_ack),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_data_write(mem_data_write), .mem_ack(mem_ack),
    .mem_data_read(mem_data_read), .bus_error(bus_error), .grant(grant)
  );

  // Who should win, straight from the arbitration rules.
  function automatic int model_pick(bit ic, bit dr, bit dw, int starve);
    if (ic && starve == LIMIT) return 1;
    if (dw) return 3;
    if (dr) return 2;
    if (ic) return 1;
    return 0;
  endfunction

  task automatic step();
    int          nack, who, exp_g;
    logic [31:0] exp_a;
    @(negedge clk);
    for (int i = 0; i < 4; i++) acked_now[i] = 1'b0;
    compared++;
    if (mem_read && mem_write) begin
      mismatched++;
      $display("FAIL rd_wr_excl: mem_read=%b mem_write=%b, required not both 1", mem_read, mem_write);
    end
    nack = int'(ic_read_ack) + int'(dc_read_ack) + int'(dc_write_ack);
    compared++;
    if (nack > 1) begin
      mismatched++;
      $display("FAIL ack_onehot: %0d acks high, required at most 1", nack);
    end
    if (grant != 2'd0 && prev_grant == 2'd0) begin
      exp_g = model_pick(ic_read_req, dc_read_req, dc_write_req, model_starve);
      compared++;
      if (grant !== 2'(exp_g)) begin
        mismatched++;
        $display("FAIL grant_pick: got %0d, required %0d", grant, exp_g);
      end
      exp_a = (exp_g == 1) ? ic_read_addr : (exp_g == 2) ? dc_read_addr : dc_write_addr;
      compared++;
      if (mem_addr !== exp_a) begin
        mismatched++;
        $display("FAIL grant_addr: got %h, required %h", mem_addr, exp_a);
      end
      if (exp_g == 3) begin
        compared++;
        if (mem_data_write !== dc_write_data) begin
          mismatched++;
          $display("FAIL grant_wdata: got %h, required %h", mem_data_write, dc_write_data);
        end
      end
      if (exp_g == 1 || !ic_read_req) model_starve = 0;
      else if (model_starve < LIMIT) model_starve++;
      grant_log.push_back(int'(grant));
      cur_owner = grant;
      busy_n    = 0;
      if (rand_mode) resp_lat = $urandom_range(1, 5);
    end
    prev_grant = grant;
    if (nack != 0) begin
      who = ic_read_ack ? 1 : dc_read_ack ? 2 : 3;
      compared++;
      if (2'(who) !== cur_owner) begin
        mismatched++;
        $display("FAIL ack_owner: ack on port %0d, required port %0d", who, cur_owner);
      end
      if (who != 3 && exp_rd_vld) begin
        compared++;
        if ((who == 1 ? ic_read_data : dc_read_data) !== exp_rd) begin
          mismatched++;
          $display("FAIL rd_data: port %0d got %h, required %h", who,
                   (who == 1 ? ic_read_data : dc_read_data), exp_rd);
        end
      end
      exp_rd_vld = 1'b0;
      ack_cnt[who]++;
      acked_now[who] = 1'b1;
      if (who == 1) ic_read_req = 1'b0;
      if (who == 2) dc_read_req = 1'b0;
      if (who == 3) dc_write_req = 1'b0;
    end
    if (mem_read || mem_write) busy_n++;
    mem_ack = 1'b0;
    if ((mem_read || mem_write) && resp_en && busy_n == resp_lat) begin
      mem_ack       = 1'b1;
      mem_data_read = fix_vld ? fix_data : $urandom;
      last_resp     = mem_data_read;
      if (mem_read) begin
        exp_rd     = mem_data_read;
        exp_rd_vld = 1'b1;
      end
    end else if (stray && !(mem_read || mem_write)) begin
      mem_ack       = 1'b1;
      mem_data_read = $urandom;
    end
  endtask

  task automatic run_quiet(input int budget, input string name);
    int n = 0;
    do begin
      step();
      n++;
    end while ((ic_read_req || dc_read_req || dc_write_req || grant != 2'd0) && n < budget);
    compared++;
    if (ic_read_req || dc_read_req || dc_write_req || grant != 2'd0) begin
      mismatched++;
      $display("FAIL %s_budget: still busy after %0d cycles, required idle", name, budget);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(negedge clk);
    compared++;
    if ({mem_read, mem_write, ic_read_ack, dc_read_ack, dc_write_ack, grant, bus_error} !== '0) begin
      mismatched++;
      $display("FAIL reset_ctrl: rd=%b wr=%b acks=%b%b%b grant=%0d err=%b, required all 0",
               mem_read, mem_write, ic_read_ack, dc_read_ack, dc_write_ack, grant, bus_error);
    end
    compared++;
    if ({mem_addr, mem_data_write, ic_read_data, dc_read_data} !== '0) begin
      mismatched++;
      $display("FAIL reset_data: addr=%h wd=%h icd=%h dcd=%h, required 0",
               mem_addr, mem_data_write, ic_read_data, dc_read_data);
    end
    compared++;
    if (dut.state !== ST_IDLE || dut.starve_cnt !== 8'd0 || dut.tmo_cnt !== 8'd0) begin
      mismatched++;
      $display("FAIL reset_state: state=%0d starve=%0d tmo=%0d, required 0/0/0",
               dut.state, dut.starve_cnt, dut.tmo_cnt);
    end
    reset = 1'b1;
    step();
  endtask

  task automatic test_ic_read();
    int bad = 0;
    resp_lat = 3; fix_vld = 1'b1; fix_data = 32'h2402_0001;
    ic_read_addr = 32'h100; ic_read_req = 1'b1;
    for (int n = 0; n < 20 && ack_cnt[1] == 0; n++) begin
      step();
      if (grant == 2'd1 && !ic_read_ack) begin
        if (mem_read !== 1'b1 || mem_addr !== 32'h100) bad++;
        ic_read_addr = 32'h999;
      end
    end
    run_quiet(10, "ic");
    fix_vld = 1'b0;
    compared++;
    if (bad != 0 || busy_n != 3) begin
      mismatched++;
      $display("FAIL ic_busy: %0d bad busy cycles over %0d, required 0 over 3", bad, busy_n);
    end
    compared++;
    if (ack_cnt[1] != 1 || ic_read_data !== 32'h2402_0001) begin
      mismatched++;
      $display("FAIL ic_read: acks=%0d data=%h, required 1 and 24020001", ack_cnt[1], ic_read_data);
    end
  endtask

  task automatic test_wr_rd();
    int start = grant_log.size();
    dc_write_addr = 32'h200; dc_write_data = 32'hCAFE; dc_write_req = 1'b1;
    dc_read_addr  = 32'h204; dc_read_req  = 1'b1;
    resp_lat = 2;
    run_quiet(30, "wr_rd");
    compared++;
    if (grant_log.size() != start + 2 || grant_log[start] != 3 || grant_log[start+1] != 2) begin
      mismatched++;
      $display("FAIL wr_rd_order: %0d grants, first=%0d, required 2 grants 3 then 2",
               grant_log.size() - start, grant_log[start]);
    end
    compared++;
    if (ic_read_data !== 32'h2402_0001) begin
      mismatched++;
      $display("FAIL ic_hold: got %h, required 24020001", ic_read_data);
    end
  endtask

  task automatic test_starve();
    int  start = grant_log.size();
    bit  seen = 1'b0;
    ic_read_addr = 32'h300; ic_read_req = 1'b1;
    resp_lat = 1;
    for (int n = 0; n < 100 && ack_cnt[1] == 1; n++) begin
      if (!dc_write_req && !acked_now[3]) begin
        dc_write_req = 1'b1; dc_write_addr = 32'h1000 + 32'(n * 4); dc_write_data = $urandom;
      end
      if (!dc_read_req && !acked_now[2]) begin
        dc_read_req = 1'b1; dc_read_addr = 32'h2000 + 32'(n * 4);
      end
      step();
      if (grant == 2'd1 && !seen) begin
        seen = 1'b1;
        compared++;
        if (dut.starve_cnt !== 8'd0) begin
          mismatched++;
          $display("FAIL starve_clear: starve_cnt=%0d, required 0", dut.starve_cnt);
        end
      end
    end
    run_quiet(30, "starve");
    compared++;
    if (grant_log.size() < start + 5 || grant_log[start+4] != 1) begin
      mismatched++;
      $display("FAIL starve_fifth: grant #5 of run is %0d, required 1 (ic)",
               (grant_log.size() >= start + 5) ? grant_log[start+4] : -1);
    end
  endtask

  task automatic test_stray_ack();
    int acks = ack_cnt[1] + ack_cnt[2] + ack_cnt[3];
    int g    = grant_log.size();
    stray = 1'b1;
    repeat (4) step();
    stray = 1'b0;
    step();
    compared++;
    if (ack_cnt[1] + ack_cnt[2] + ack_cnt[3] != acks || grant_log.size() != g || dut.state !== ST_IDLE) begin
      mismatched++;
      $display("FAIL stray_ack: acks %0d->%0d grants %0d->%0d, required unchanged",
               acks, ack_cnt[1] + ack_cnt[2] + ack_cnt[3], g, grant_log.size());
    end
  endtask

  task automatic test_timeout_ack();
    resp_lat = TMO;
    dc_read_addr = 32'h500; dc_read_req = 1'b1;
    run_quiet(300, "tmo_ack");
    compared++;
    if (busy_n != TMO || bus_error !== 1'b0 || dc_read_data !== last_resp) begin
      mismatched++;
      $display("FAIL tmo_ack: busy=%0d err=%b data=%h, required %0d/0/%h",
               busy_n, bus_error, dc_read_data, TMO, last_resp);
    end
  endtask

  task automatic test_timeout();
    resp_en = 1'b0;
    dc_read_addr = 32'h400; dc_read_req = 1'b1;
    run_quiet(300, "tmo");
    resp_en = 1'b1;
    compared++;
    if (busy_n != TMO || dc_read_data !== BUS_ERR_DATA || bus_error !== 1'b1) begin
      mismatched++;
      $display("FAIL timeout: busy=%0d data=%h err=%b, required %0d/deadbeef/1",
               busy_n, dc_read_data, bus_error, TMO);
    end
    resp_lat = 2;
    ic_read_addr = 32'h600; ic_read_req = 1'b1;
    run_quiet(20, "post_tmo");
    compared++;
    if (bus_error !== 1'b1) begin
      mismatched++;
      $display("FAIL err_sticky: bus_error=%b, required 1", bus_error);
    end
  endtask

  task automatic test_random();
    rand_mode = 1'b1;
    for (int n = 0; n < 300; n++) begin
      if (!ic_read_req && !acked_now[1] && $urandom_range(0, 2) == 0) begin
        ic_read_req = 1'b1; ic_read_addr = $urandom & 32'hFFFF_FFFC;
      end
      if (!dc_read_req && !acked_now[2] && $urandom_range(0, 2) == 0) begin
        dc_read_req = 1'b1; dc_read_addr = $urandom & 32'hFFFF_FFFC;
      end
      if (!dc_write_req && !acked_now[3] && $urandom_range(0, 2) == 0) begin
        dc_write_req = 1'b1; dc_write_addr = $urandom & 32'hFFFF_FFFC; dc_write_data = $urandom;
      end
      step();
    end
    run_quiet(60, "random");
    rand_mode = 1'b0;
  endtask

  task automatic test_reset_mid();
    int wacks = ack_cnt[3];
    resp_en = 1'b0;
    dc_write_addr = 32'h700; dc_write_data = 32'h1234_5678; dc_write_req = 1'b1;
    for (int n = 0; n < 10 && busy_n < 3; n++) step();
    reset = 1'b0;
    #1;
    compared++;
    if (mem_write !== 1'b0 || grant !== 2'd0 || dc_write_ack !== 1'b0 || bus_error !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_mid: wr=%b grant=%0d ack=%b err=%b, required 0/0/0/0",
               mem_write, grant, dc_write_ack, bus_error);
    end
    dc_write_req = 1'b0;
    resp_en = 1'b1;
    repeat (2) step();
    reset = 1'b1;
    model_starve = 0;
    step();
    compared++;
    if (dut.state !== ST_IDLE || grant !== 2'd0 || ack_cnt[3] != wacks) begin
      mismatched++;
      $display("FAIL reset_release: state=%0d grant=%0d wacks=%0d, required IDLE/0/%0d",
               dut.state, grant, ack_cnt[3], wacks);
    end
    dc_write_req = 1'b1;
    run_quiet(20, "post_reset");
    compared++;
    if (ack_cnt[3] != wacks + 1) begin
      mismatched++;
      $display("FAIL restart: write acks=%0d, required %0d", ack_cnt[3], wacks + 1);
    end
  endtask

  initial begin
    ic_read_req = 1'b0; dc_read_req = 1'b0; dc_write_req = 1'b0;
    ic_read_addr = '0; dc_read_addr = '0; dc_write_addr = '0; dc_write_data = '0;
    mem_ack = 1'b0; mem_data_read = '0;
    busy_n = 0; resp_en = 1'b1; rand_mode = 1'b0; stray = 1'b0; fix_vld = 1'b0;
    resp_lat = 2; fix_data = '0; exp_rd = '0; last_resp = '0; exp_rd_vld = 1'b0;
    model_starve = 0; prev_grant = 2'd0; cur_owner = 2'd0;
    for (int i = 0; i < 4; i++) begin
      ack_cnt[i] = 0;
      acked_now[i] = 1'b0;
    end
    test_reset();
    test_ic_read();
    test_wr_rd();
    test_starve();
    test_stray_ack();
    test_timeout_ack();
    test_timeout();
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
